// File: rtl/movegen_host.sv
// -----------------------------------------------------------------------------
// movegen_host
//
// Host-side sequencer for a move-generator accelerator. It accepts one command
// (piece id, input board address, output base address) and programs the
// generator over an Avalon-MM master port:
//   reg 1 <= board address, reg 2 <= sign-extended piece, reg 3 <= out address,
//   reg 0 <= 1 (start), then a read of reg 0, which the generator stalls until
//   generation is done and which returns the number of boards written.
// The result is reported with a one-cycle resp_valid pulse.
//
// Optional feature (macro MOVEGEN_TIMEOUT_EN): a watchdog on the status read.
// After TIMEOUT_CYCLES stalled cycles it abandons the read and responds with
// resp_error=1, resp_count=0. Without the macro the read waits indefinitely
// and resp_error is constant 0.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (ready only while idle)
//   cmd_piece                signed 8-bit piece id
//   cmd_board_addr           byte address of the 64-byte input board
//   cmd_out_addr             byte address of the first output board
//   resp_valid               one-cycle completion pulse
//   resp_count, resp_error   result, held until the next accepted command
//   gen_address, gen_write, gen_read, gen_writedata,
//   gen_readdata, gen_waitrequest   Avalon-MM master to the generator
// -----------------------------------------------------------------------------
module movegen_host #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic signed [7:0]  cmd_piece,
    input  logic [31:0]        cmd_board_addr,
    input  logic [31:0]        cmd_out_addr,
    output logic               resp_valid,
    output logic [31:0]        resp_count,
    output logic               resp_error,
    output logic [3:0]         gen_address,
    output logic               gen_write,
    output logic               gen_read,
    output logic [31:0]        gen_writedata,
    input  logic [31:0]        gen_readdata,
    input  logic               gen_waitrequest
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_BOARD,
        S_WR_PIECE,
        S_WR_OUT,
        S_WR_START,
        S_RD_STATUS,
        S_RESP
    } state_t;

    localparam logic [3:0] REG_CTRL  = 4'd0;
    localparam logic [3:0] REG_BOARD = 4'd1;
    localparam logic [3:0] REG_PIECE = 4'd2;
    localparam logic [3:0] REG_OUT   = 4'd3;

    state_t      state_q;
    logic        cmd_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_count_q;
    logic [3:0]  gen_address_q;
    logic        gen_write_q;
    logic        gen_read_q;
    logic [31:0] gen_writedata_q;
    logic [31:0] piece_ext_q;
    logic [31:0] out_addr_q;

    // Piece ids are signed; the generator register expects a 32-bit value.
    function automatic logic [31:0] sext_piece(input logic signed [7:0] p);
        return {{24{p[7]}}, p};
    endfunction

`ifdef MOVEGEN_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic              resp_error_q;
    logic [WDOG_W-1:0] wdog_q;
    logic [WDOG_W-1:0] wdog_d;
    logic              wdog_expired;

    always_comb begin
        wdog_d       = wdog_q + WDOG_W'(1);
        // wdog_q counts stalled status cycles already seen; this edge would
        // be the TIMEOUT_CYCLES-th one.
        wdog_expired = (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
    end

    assign resp_error = resp_error_q;
`else
    // The watchdog limit only matters when the watchdog is built.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end

    assign resp_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cmd_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_count_q    <= '0;
            gen_address_q   <= '0;
            gen_write_q     <= 1'b0;
            gen_read_q      <= 1'b0;
            gen_writedata_q <= '0;
            piece_ext_q     <= '0;
            out_addr_q      <= '0;
`ifdef MOVEGEN_TIMEOUT_EN
            resp_error_q    <= 1'b0;
            wdog_q          <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        // Board address goes straight into the first write;
                        // the other two fields are kept for later writes.
                        state_q         <= S_WR_BOARD;
                        cmd_ready_q     <= 1'b0;
                        gen_write_q     <= 1'b1;
                        gen_address_q   <= REG_BOARD;
                        gen_writedata_q <= cmd_board_addr;
                        piece_ext_q     <= sext_piece(cmd_piece);
                        out_addr_q      <= cmd_out_addr;
                        resp_count_q    <= '0;
`ifdef MOVEGEN_TIMEOUT_EN
                        resp_error_q    <= 1'b0;
`endif
                    end
                end
                S_WR_BOARD: begin
                    if (!gen_waitrequest) begin
                        state_q         <= S_WR_PIECE;
                        gen_address_q   <= REG_PIECE;
                        gen_writedata_q <= piece_ext_q;
                    end
                end
                S_WR_PIECE: begin
                    if (!gen_waitrequest) begin
                        state_q         <= S_WR_OUT;
                        gen_address_q   <= REG_OUT;
                        gen_writedata_q <= out_addr_q;
                    end
                end
                S_WR_OUT: begin
                    if (!gen_waitrequest) begin
                        state_q         <= S_WR_START;
                        gen_address_q   <= REG_CTRL;
                        gen_writedata_q <= 32'd1;
                    end
                end
                S_WR_START: begin
                    if (!gen_waitrequest) begin
                        state_q         <= S_RD_STATUS;
                        gen_write_q     <= 1'b0;
                        gen_read_q      <= 1'b1;
                        gen_address_q   <= REG_CTRL;
                        gen_writedata_q <= '0;
`ifdef MOVEGEN_TIMEOUT_EN
                        wdog_q          <= '0;
`endif
                    end
                end
                S_RD_STATUS: begin
                    if (!gen_waitrequest) begin
                        state_q      <= S_RESP;
                        gen_read_q   <= 1'b0;
                        resp_count_q <= gen_readdata;
                        resp_valid_q <= 1'b1;
`ifdef MOVEGEN_TIMEOUT_EN
                    end else if (wdog_expired) begin
                        // Abandon the stalled read and report the failure.
                        state_q      <= S_RESP;
                        gen_read_q   <= 1'b0;
                        resp_count_q <= '0;
                        resp_error_q <= 1'b1;
                        resp_valid_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_d;
`endif
                    end
                end
                S_RESP: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    cmd_ready_q  <= 1'b1;
                end
                default: begin
                    state_q      <= S_IDLE;
                    cmd_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    gen_write_q  <= 1'b0;
                    gen_read_q   <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_count    = resp_count_q;
    assign gen_address   = gen_address_q;
    assign gen_write     = gen_write_q;
    assign gen_read      = gen_read_q;
    assign gen_writedata = gen_writedata_q;

endmodule
